// File: rtl/garegga_sndlatch_fifo.sv
// Sound command latch between the 68k and the sound block.
// The 68k queues command bytes in a small FIFO. A sequencer presents each one
// on SOUNDLATCH, raises Z80INT for a fixed pulse, waits for the sound block
// to acknowledge via WAIT (or times out), then idles briefly before the next.
module garegga_sndlatch_fifo #(
    parameter int DEPTH       = 4,
    parameter int PULSE_LEN   = 16,
    parameter int ACK_TIMEOUT = 1048576,
    parameter int GAP_LEN     = 4
) (
    input  logic       CLK96,
    input  logic       RESET96,
    input  logic       CPU_CS,
    input  logic       CPU_WR,
    input  logic       CPU_A0,
    input  logic [7:0] CPU_DIN,
    output logic [7:0] CPU_DOUT,
    output logic [7:0] SOUNDLATCH,
    output logic       Z80INT,
    input  logic       WAIT,
    output logic       OVERFLOW,
    output logic       TIMEOUT_ERR
);

    localparam int CW   = $clog2(DEPTH + 1);
    localparam int PW   = $clog2(DEPTH);
    localparam int MAXC = (ACK_TIMEOUT > PULSE_LEN)
                        ? ((ACK_TIMEOUT > GAP_LEN) ? ACK_TIMEOUT : GAP_LEN)
                        : ((PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN);
    localparam int TW   = $clog2(MAXC + 1);

    localparam logic [TW-1:0] PULSE_LAST = TW'(PULSE_LEN - 1);
    localparam logic [TW-1:0] ACK_LAST   = TW'(ACK_TIMEOUT - 1);
    localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_LEN - 1);
    localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        PULSE,
        ACKWAIT,
        GAP
    } state_t;

    state_t          state, state_nxt;
    logic [TW-1:0]   timer, timer_nxt;
    logic            seen_high, seen_high_nxt;
    logic            to_set;

    logic [7:0]      mem [DEPTH];
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count;

    logic            data_wr, ctrl_wr, rd_strobe;
    logic            flush, clr_ovf, clr_to;
    logic            fifo_full, fifo_empty;
    logic            pop, push_ok, ovf_set;
    logic [31:0]     count_ext;
    logic [2:0]      count_sat;
    logic [7:0]      status;
    logic            unused_din;

    // Bus decode and FIFO handshake terms.
    always_comb begin
        data_wr    = CPU_CS & CPU_WR & ~CPU_A0;
        ctrl_wr    = CPU_CS & CPU_WR & CPU_A0;
        rd_strobe  = CPU_CS & ~CPU_WR;
        flush      = ctrl_wr & CPU_DIN[7];
        clr_ovf    = ctrl_wr & CPU_DIN[0];
        clr_to     = ctrl_wr & CPU_DIN[1];
        fifo_full  = (count == FULL_CNT);
        fifo_empty = (count == '0);
        pop        = (state == LOAD) & ~fifo_empty;
        // A pop in the same clock frees the slot the push needs.
        push_ok    = data_wr & (~fifo_full | pop);
        ovf_set    = data_wr & fifo_full & ~pop;
        unused_din = ^CPU_DIN[6:2];
    end

    // Status byte assembled from current state; count saturates at 7.
    always_comb begin
        count_ext = 32'(count);
        count_sat = (count_ext > 32'd7) ? 3'd7 : count_ext[2:0];
        status    = {fifo_full, fifo_empty, (state != IDLE), OVERFLOW,
                     TIMEOUT_ERR, count_sat};
    end

    // Sequencer next-state logic with shared phase timer.
    always_comb begin
        state_nxt     = state;
        timer_nxt     = timer;
        seen_high_nxt = seen_high;
        to_set        = 1'b0;
        case (state)
            IDLE: begin
                timer_nxt = '0;
                if (!fifo_empty && !flush) state_nxt = LOAD;
            end
            LOAD: begin
                // seen_high is cleared here rather than on ACKWAIT entry so
                // an acknowledge already seen during PULSE is preserved.
                seen_high_nxt = 1'b0;
                timer_nxt     = '0;
                state_nxt     = fifo_empty ? IDLE : PULSE;
            end
            PULSE: begin
                if (WAIT) seen_high_nxt = 1'b1;
                if (timer == PULSE_LAST) begin
                    state_nxt = ACKWAIT;
                    timer_nxt = '0;
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end
            ACKWAIT: begin
                if (WAIT) seen_high_nxt = 1'b1;
                if (!WAIT && seen_high) begin
                    state_nxt = GAP;
                    timer_nxt = '0;
                end else if (timer == ACK_LAST) begin
                    to_set    = 1'b1;
                    state_nxt = GAP;
                    timer_nxt = '0;
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end
            GAP: begin
                if (timer == GAP_LAST) begin
                    state_nxt = IDLE;
                    timer_nxt = '0;
                end else begin
                    timer_nxt = timer + TW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                timer_nxt = '0;
            end
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge CLK96) begin
        if (RESET96) begin
            state     <= IDLE;
            timer     <= '0;
            seen_high <= 1'b0;
        end else begin
            state     <= state_nxt;
            timer     <= timer_nxt;
            seen_high <= seen_high_nxt;
        end
    end

    // FIFO storage write port.
    always_ff @(posedge CLK96) begin
        if (push_ok && !RESET96 && !flush) mem[wr_ptr] <= CPU_DIN;
    end

    // FIFO pointers and occupancy; flush empties without touching SOUNDLATCH.
    always_ff @(posedge CLK96) begin
        if (RESET96 || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop)     rd_ptr <= rd_ptr + PW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Command latch and interrupt line; Z80INT is high exactly while in PULSE.
    always_ff @(posedge CLK96) begin
        if (RESET96) begin
            SOUNDLATCH <= 8'h00;
            Z80INT     <= 1'b0;
        end else begin
            if (pop) SOUNDLATCH <= mem[rd_ptr];
            Z80INT <= (state_nxt == PULSE);
        end
    end

    // Sticky error flags; a set in the same clock as a clear wins.
    always_ff @(posedge CLK96) begin
        if (RESET96) begin
            OVERFLOW    <= 1'b0;
            TIMEOUT_ERR <= 1'b0;
        end else begin
            OVERFLOW    <= ovf_set | (OVERFLOW & ~clr_ovf);
            TIMEOUT_ERR <= to_set | (TIMEOUT_ERR & ~clr_to);
        end
    end

    // Registered 68k read data, held between read strobes.
    always_ff @(posedge CLK96) begin
        if (RESET96) begin
            CPU_DOUT <= 8'h00;
        end else if (rd_strobe) begin
            CPU_DOUT <= CPU_A0 ? status : SOUNDLATCH;
        end
    end

endmodule

// File: tb/tb_garegga_sndlatch_fifo.sv
// Bench for the sound command latch FIFO: scoreboard of expected command
// bytes checked at each Z80INT rise, plus status/flag checks per scenario.
module tb_garegga_sndlatch_fifo;

    localparam int PULSE_LEN   = 16;
    localparam int ACK_TIMEOUT = 64;

    logic       CLK96 = 1'b0;
    logic       RESET96;
    logic       CPU_CS, CPU_WR, CPU_A0;
    logic [7:0] CPU_DIN;
    logic [7:0] CPU_DOUT;
    logic [7:0] SOUNDLATCH;
    logic       Z80INT;
    logic       WAIT;
    logic       OVERFLOW;
    logic       TIMEOUT_ERR;

    typedef enum {W_AUTO, W_MANUAL} wmode_t;
    wmode_t wait_mode = W_AUTO;
    logic   wait_lvl  = 1'b0;
    logic   wait_auto = 1'b0;
    assign WAIT = (wait_mode == W_MANUAL) ? wait_lvl : wait_auto;

    int checks   = 0;
    int failures = 0;

    logic [7:0] sb[$];

    garegga_sndlatch_fifo #(
        .DEPTH(4),
        .PULSE_LEN(PULSE_LEN),
        .ACK_TIMEOUT(ACK_TIMEOUT),
        .GAP_LEN(4)
    ) dut (
        .CLK96(CLK96),
        .RESET96(RESET96),
        .CPU_CS(CPU_CS),
        .CPU_WR(CPU_WR),
        .CPU_A0(CPU_A0),
        .CPU_DIN(CPU_DIN),
        .CPU_DOUT(CPU_DOUT),
        .SOUNDLATCH(SOUNDLATCH),
        .Z80INT(Z80INT),
        .WAIT(WAIT),
        .OVERFLOW(OVERFLOW),
        .TIMEOUT_ERR(TIMEOUT_ERR)
    );

    always #5 CLK96 = ~CLK96;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor: scoreboard on Z80INT rise, pulse width, timeout delay, WAIT model.
    int   cyc = 0, fall_cyc = 0, hi_len = 0, wcnt = 0;
    logic z_prev = 1'b0, to_prev = 1'b0, aborted = 1'b0;
    always @(posedge CLK96) begin
        logic rise;
        #1;
        cyc++;
        rise = Z80INT && !z_prev;
        if (RESET96) begin
            aborted   = 1'b1;
            wcnt      = 0;
            wait_auto = 1'b0;
        end
        if (rise) begin
            hi_len  = 1;
            aborted = 1'b0;
            check("cmd_expected", (sb.size() != 0), 1);
            if (sb.size() != 0) check("latch_value", SOUNDLATCH, sb.pop_front());
        end else if (Z80INT) begin
            hi_len++;
        end
        if (!Z80INT && z_prev) begin
            if (!aborted) check("pulse_len", hi_len, PULSE_LEN);
            fall_cyc = cyc;
        end
        if (TIMEOUT_ERR && !to_prev) check("timeout_delay", cyc - fall_cyc, ACK_TIMEOUT);
        if (wait_mode == W_AUTO && !RESET96) begin
            if (rise) begin
                wcnt = 1;
            end else if (wcnt > 0) begin
                wcnt++;
                if (wcnt == 3) wait_auto = 1'b1;
                if (wcnt == 53) begin
                    wait_auto = 1'b0;
                    wcnt      = 0;
                end
            end
        end
        z_prev  = Z80INT;
        to_prev = TIMEOUT_ERR;
    end

    task automatic bus_write(input logic a0, input logic [7:0] d);
        @(negedge CLK96);
        CPU_CS = 1'b1; CPU_WR = 1'b1; CPU_A0 = a0; CPU_DIN = d;
        @(posedge CLK96);
        #1;
        CPU_CS = 1'b0; CPU_WR = 1'b0;
    endtask

    task automatic bus_read(input logic a0, output logic [7:0] d);
        @(negedge CLK96);
        CPU_CS = 1'b1; CPU_WR = 1'b0; CPU_A0 = a0;
        @(posedge CLK96);
        #1;
        d = CPU_DOUT;
        CPU_CS = 1'b0;
    endtask

    task automatic wait_level(input logic lvl, input int bound, input string tag);
        int n = 0;
        while (Z80INT !== lvl && n < bound) begin
            @(posedge CLK96);
            #1;
            n++;
        end
        check(tag, Z80INT, lvl);
    endtask

    task automatic wait_idle(input int bound, input string tag, input logic [7:0] exp);
        logic [7:0] st;
        int n = 0;
        do begin
            bus_read(1'b1, st);
            n++;
        end while ((st[5] || sb.size() != 0) && n < bound);
        check(tag, st, exp);
    endtask

    initial begin
        repeat (50000) @(posedge CLK96);
        $display("FAIL watchdog: cycle budget exhausted");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] st;
        RESET96 = 1'b1;
        CPU_CS = 1'b0; CPU_WR = 1'b0; CPU_A0 = 1'b0; CPU_DIN = 8'h00;

        // Reset state
        repeat (3) @(posedge CLK96);
        #1;
        check("rst_z80int", Z80INT, 0);
        check("rst_latch", SOUNDLATCH, 8'h00);
        check("rst_dout", CPU_DOUT, 8'h00);
        check("rst_ovf", OVERFLOW, 0);
        check("rst_to", TIMEOUT_ERR, 0);
        @(negedge CLK96);
        RESET96 = 1'b0;
        bus_read(1'b1, st);
        check("rst_status", st, 8'h40);

        // Single command with auto acknowledge
        sb.push_back(8'h5A);
        bus_write(1'b0, 8'h5A);
        wait_idle(400, "t1_idle_status", 8'h40);
        check("t1_latch_hold", SOUNDLATCH, 8'h5A);
        bus_read(1'b0, st);
        check("t1_latch_read", st, 8'h5A);

        // Burst while busy: fifth byte dropped
        sb.push_back(8'hA0);
        bus_write(1'b0, 8'hA0);
        wait_level(1'b1, 20, "t2_prime_rise");
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) sb.push_back(8'(i));
            bus_write(1'b0, 8'(i));
        end
        check("t2_ovf", OVERFLOW, 1);
        bus_read(1'b1, st);
        check("t2_status_full", st, 8'hB4);
        wait_idle(600, "t2_idle_status", 8'h50);
        bus_write(1'b1, 8'h01);
        bus_read(1'b1, st);
        check("t2_ovf_cleared", st, 8'h40);

        // Full FIFO, push in the same clock as LOAD
        wait_mode = W_MANUAL;
        wait_lvl  = 1'b0;
        sb.push_back(8'hE0);
        bus_write(1'b0, 8'hE0);
        wait_level(1'b1, 20, "t3_prime_rise");
        @(negedge CLK96);
        wait_lvl = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            sb.push_back(8'hE0 + 8'(i));
            bus_write(1'b0, 8'hE0 + 8'(i));
        end
        bus_read(1'b1, st);
        check("t3_status_full", st, 8'hA4);
        wait_level(1'b0, 40, "t3_ackwait_entry");
        repeat (3) @(negedge CLK96);
        wait_lvl  = 1'b0;
        wait_mode = W_AUTO;
        repeat (5) @(negedge CLK96);
        sb.push_back(8'hE5);
        bus_write(1'b0, 8'hE5);
        check("t3_rise_at_load_push", Z80INT, 1);
        check("t3_ovf_clear", OVERFLOW, 0);
        bus_read(1'b1, st);
        check("t3_count_kept", st, 8'hA4);
        wait_idle(800, "t3_idle_status", 8'h40);

        // No acknowledge: timeout, then next command still runs
        wait_mode = W_MANUAL;
        wait_lvl  = 1'b0;
        sb.push_back(8'h11);
        sb.push_back(8'h22);
        bus_write(1'b0, 8'h11);
        bus_write(1'b0, 8'h22);
        wait_idle(600, "t4_idle_status", 8'h48);
        check("t4_to_flag", TIMEOUT_ERR, 1);
        bus_write(1'b1, 8'h02);
        check("t4_to_cleared", TIMEOUT_ERR, 0);
        bus_read(1'b1, st);
        check("t4_status_clear", st, 8'h40);

        // Reset mid-PULSE with three queued
        wait_mode = W_AUTO;
        sb.push_back(8'hC0);
        bus_write(1'b0, 8'hC0);
        wait_level(1'b1, 20, "t5_prime_rise");
        for (int i = 1; i <= 3; i++) begin
            sb.push_back(8'hC0 + 8'(i));
            bus_write(1'b0, 8'hC0 + 8'(i));
        end
        bus_read(1'b1, st);
        check("t5_status_q3", st, 8'h23);
        @(negedge CLK96);
        RESET96 = 1'b1;
        sb.delete();
        @(posedge CLK96);
        #1;
        check("t5_z80int", Z80INT, 0);
        check("t5_latch", SOUNDLATCH, 8'h00);
        check("t5_dout", CPU_DOUT, 8'h00);
        @(negedge CLK96);
        RESET96 = 1'b0;
        bus_read(1'b1, st);
        check("t5_status", st, 8'h40);
        repeat (80) @(posedge CLK96);
        #1;
        bus_read(1'b1, st);
        check("t5_stays_idle", st, 8'h40);

        // Flush during ACKWAIT with three queued
        sb.push_back(8'hD0);
        bus_write(1'b0, 8'hD0);
        wait_level(1'b1, 20, "t6_prime_rise");
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) sb.push_back(8'hD0 + 8'(i));
            bus_write(1'b0, 8'hD0 + 8'(i));
        end
        check("t6_ovf_set", OVERFLOW, 1);
        wait_level(1'b0, 40, "t6_d0_fall");
        wait_level(1'b1, 100, "t6_d1_rise");
        wait_level(1'b0, 40, "t6_d1_fall");
        bus_read(1'b1, st);
        check("t6_status_q3", st, 8'h33);
        bus_write(1'b1, 8'h81);
        sb.delete();
        bus_read(1'b1, st);
        check("t6_status_flushed", st, 8'h60);
        check("t6_latch_kept", SOUNDLATCH, 8'hD1);
        wait_idle(200, "t6_idle_status", 8'h40);
        repeat (80) @(posedge CLK96);
        #1;
        check("t6_no_more_cmds", Z80INT, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
